// File: rtl/conv_pkg.sv
// Shared types, default geometry and pointer helper for the KxK convolution
// window controller and its line stores.
package conv_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_e;

  localparam int unsigned DEF_PIX_W = 8;
  localparam int unsigned DEF_IMG_W = 512;
  localparam int unsigned DEF_K     = 3;

  // Advance a line-store pointer, wrapping after the last of nlb stores.
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned nlb);
    return (ptr >= nlb - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/line_store.sv
// One image row of pixels: synchronous single write port and a combinational
// read of K consecutive pixels starting at raddr_i.
module line_store
  import conv_pkg::*;
#(
  parameter int unsigned PIX_W = DEF_PIX_W,
  parameter int unsigned IMG_W = DEF_IMG_W,
  parameter int unsigned K     = DEF_K,
  parameter int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [COL_W-1:0]   waddr_i,
  input  logic [PIX_W-1:0]   wdata_i,
  input  logic [COL_W-1:0]   raddr_i,
  output logic [K*PIX_W-1:0] rdata_o
);

  logic [PIX_W-1:0] mem_q [IMG_W];

  // NOTE: the storage array has no reset; a row is always fully rewritten
  // before any window reads it, so clearing it would only cost logic.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int j = 0; j < int'(K); j++) begin
      if (int'(raddr_i) + j < int'(IMG_W)) begin
        rdata_o[j*PIX_W +: PIX_W] = mem_q[COL_W'(int'(raddr_i) + j)];
      end
    end
  end

endmodule

// File: rtl/conv_window_ctrl.sv
// Line-buffer controller for KxK convolution: writes a raster pixel stream into
// K+1 rotating line stores and emits one KxK window per output handshake.
module conv_window_ctrl
  import conv_pkg::*;
#(
  parameter int unsigned PIX_W = DEF_PIX_W,
  parameter int unsigned IMG_W = DEF_IMG_W,
  parameter int unsigned K     = DEF_K
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PIX_W-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [K*K*PIX_W-1:0] out_window,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 row_done_intr
);

  localparam int unsigned NLB   = K + 1;
  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned PTR_W = $clog2(NLB);
  localparam int unsigned CNT_W = $clog2(NLB + 1);
  localparam logic [COL_W-1:0] WCOL_LAST = COL_W'(IMG_W - 1);
  localparam logic [COL_W-1:0] RCOL_LAST = COL_W'(IMG_W - K);

  state_e           state_q, state_d;
  logic [COL_W-1:0] wcol_q, wcol_d, rcol_q, rcol_d;
  logic [PTR_W-1:0] wbuf_q, wbuf_d, rbuf_q, rbuf_d;
  logic [CNT_W-1:0] rows_full_q, rows_full_d;
  logic             intr_q, intr_d;
  logic             wr_acc, wr_row_end, rd_hs, rd_row_end;
  logic [K*PIX_W-1:0] rd_data [NLB];

  assign in_ready      = (rows_full_q < CNT_W'(NLB));
  assign out_valid     = (state_q == READ);
  assign row_done_intr = intr_q;

  assign wr_acc     = in_valid & in_ready;
  assign wr_row_end = wr_acc & (wcol_q == WCOL_LAST);
  assign rd_hs      = out_valid & out_ready;
  assign rd_row_end = rd_hs & (rcol_q == RCOL_LAST);

  for (genvar s = 0; s < int'(NLB); s++) begin : g_store
    line_store #(
      .PIX_W (PIX_W),
      .IMG_W (IMG_W),
      .K     (K),
      .COL_W (COL_W)
    ) u_store (
      .clk     (clk),
      .we_i    (wr_acc && (wbuf_q == PTR_W'(s))),
      .waddr_i (wcol_q),
      .wdata_i (in_data),
      .raddr_i (rcol_q),
      .rdata_o (rd_data[s])
    );
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the block can leave it unassigned and infer a latch.
  always_comb begin
    wcol_d      = wcol_q;
    wbuf_d      = wbuf_q;
    rcol_d      = rcol_q;
    rbuf_d      = rbuf_q;
    rows_full_d = rows_full_q;
    state_d     = state_q;
    intr_d      = rd_row_end;

    if (wr_row_end) begin
      wcol_d = '0;
      wbuf_d = PTR_W'(wrap_inc(32'(wbuf_q), NLB));
    end else if (wr_acc) begin
      wcol_d = wcol_q + COL_W'(1);
    end

    if (rd_row_end) begin
      rcol_d = '0;
      rbuf_d = PTR_W'(wrap_inc(32'(rbuf_q), NLB));
    end else if (rd_hs) begin
      rcol_d = rcol_q + COL_W'(1);
    end

    // A row finishing on both sides in the same cycle leaves the count as is.
    if (wr_row_end && !rd_row_end) begin
      rows_full_d = rows_full_q + CNT_W'(1);
    end else if (rd_row_end && !wr_row_end) begin
      rows_full_d = rows_full_q - CNT_W'(1);
    end

    unique case (state_q)
      IDLE:    if (rows_full_q >= CNT_W'(K)) state_d = READ;
      READ:    if (rd_row_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Window row i comes from store rbuf+i (mod NLB), oldest row first.
  always_comb begin
    out_window = '0;
    for (int i = 0; i < int'(K); i++) begin
      for (int j = 0; j < int'(K); j++) begin
        out_window[(i*int'(K)+j)*PIX_W +: PIX_W] =
          rd_data[PTR_W'((32'(rbuf_q) + 32'(i)) % NLB)][j*PIX_W +: PIX_W];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wcol_q      <= '0;
      rcol_q      <= '0;
      wbuf_q      <= '0;
      rbuf_q      <= '0;
      rows_full_q <= '0;
      intr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcol_q      <= wcol_d;
      rcol_q      <= rcol_d;
      wbuf_q      <= wbuf_d;
      rbuf_q      <= rbuf_d;
      rows_full_q <= rows_full_d;
      intr_q      <= intr_d;
    end
  end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Self-checking bench for conv_window_ctrl: a row-queue model checks every
// cycle, directed scenarios pin latency, rotation, backpressure and reset.
module tb_conv_window_ctrl;

  localparam int PIX_W = 8;
  localparam int IMG_W = 8;
  localparam int K     = 3;
  localparam int NLB   = K + 1;
  localparam int NWIN  = IMG_W - K + 1;
  localparam int WIN_W = K * K * PIX_W;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [PIX_W-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIN_W-1:0] out_window;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             row_done_intr;

  conv_window_ctrl #(.PIX_W(PIX_W), .IMG_W(IMG_W), .K(K)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .out_window    (out_window),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .row_done_intr (row_done_intr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: completed rows not yet consumed, flattened, oldest first.
  logic [PIX_W-1:0] store_q [$];
  logic [PIX_W-1:0] cur_q [$];
  int               rc;
  logic             exp_intr;
  int               idle_run;
  logic             prev_stall;
  logic [WIN_W-1:0] prev_win;
  logic             m_rdy, m_hs, m_acc, m_nintr;

  int               cyc = 0;
  int               acc_cnt, acc24_cyc, first_valid_cyc, win_cnt, intr_cnt;
  logic [WIN_W-1:0] first_win;
  logic [WIN_W-1:0] win_log [64];

  function automatic int nrows();
    return store_q.size() / IMG_W;
  endfunction

  function automatic logic [WIN_W-1:0] model_window();
    logic [WIN_W-1:0] w;
    w = '0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        w[(i*K+j)*PIX_W +: PIX_W] = store_q[i*IMG_W + rc + j];
    return w;
  endfunction

  task automatic clear_stats();
    acc_cnt = 0;
    acc24_cyc = -1;
    first_valid_cyc = -1;
    win_cnt = 0;
    intr_cnt = 0;
    first_win = '0;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      store_q.delete();
      cur_q.delete();
      rc = 0;
      exp_intr = 1'b0;
      idle_run = 0;
      prev_stall = 1'b0;
    end else begin
      m_rdy = (nrows() < NLB);
      check("in_ready", 128'(in_ready), 128'(m_rdy));
      check("row_done_intr", 128'(row_done_intr), 128'(exp_intr));
      if (row_done_intr) intr_cnt++;
      if (prev_stall) begin
        check("stall_valid", 128'(out_valid), 128'(1'b1));
        check("stall_window", 128'(out_window), 128'(prev_win));
      end
      if (out_valid) begin
        idle_run = 0;
        if (nrows() < K) check("valid_without_rows", 128'(nrows()), 128'(K));
        else check("window", 128'(out_window), 128'(model_window()));
        if (first_valid_cyc < 0) begin
          first_valid_cyc = cyc;
          first_win = out_window;
        end
      end else if (nrows() >= K) begin
        idle_run++;
        check("bubble_len_ok", 128'(idle_run <= 1), 128'(1'b1));
      end else begin
        idle_run = 0;
      end

      m_hs = out_valid & out_ready;
      m_acc = in_valid & m_rdy;
      m_nintr = 1'b0;
      prev_stall = out_valid & ~out_ready;
      prev_win = out_window;
      if (m_hs) begin
        if (win_cnt < 64) win_log[win_cnt] = out_window;
        win_cnt++;
        rc++;
        if (rc == NWIN) begin
          rc = 0;
          m_nintr = 1'b1;
          for (int p = 0; p < IMG_W; p++)
            if (store_q.size() > 0) store_q.delete(0);
        end
      end
      if (m_acc) begin
        cur_q.push_back(in_data);
        acc_cnt++;
        if (acc_cnt == 24) acc24_cyc = cyc;
        if (cur_q.size() == IMG_W) begin
          foreach (cur_q[p]) store_q.push_back(cur_q[p]);
          cur_q.delete();
        end
      end
      exp_intr = m_nintr;
    end
  end

  // out_ready driver: 0 = follow or_fixed, 1 = toggle every cycle, 2 = random.
  int   or_mode  = 0;
  logic or_fixed = 1'b1;
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (or_mode)
        0:       out_ready = or_fixed;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  int g_row = 0;
  int g_col = 0;
  bit gap_mode = 1'b0;

  function automatic logic [PIX_W-1:0] pix(input int r, input int c);
    return PIX_W'((r * 16 + c) & 255);
  endfunction

  task automatic advance();
    g_col++;
    if (g_col == IMG_W) begin
      g_col = 0;
      g_row++;
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Streams n pixels; each waits (bounded) for in_ready before its accept edge.
  task automatic send_pix(input int n);
    for (int p = 0; p < n; p++) begin
      int gap;
      int waited;
      gap = gap_mode ? int'($urandom_range(0, 2)) : 0;
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        in_data = PIX_W'($urandom);
        @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data = pix(g_row, g_col);
      waited = 0;
      @(negedge clk);
      while (!in_ready && waited < 200) begin
        @(negedge clk);
        waited++;
      end
      if (!in_ready) begin
        check("accept_timeout", 128'(in_ready), 128'(1'b1));
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      advance();
    end
    in_valid = 1'b0;
  endtask

  // Returns at the negedge where the n-th handshake is observed.
  task automatic wait_hs(input int n);
    int hs;
    int t;
    hs = 0;
    t = 0;
    while (hs < n && t < 500) begin
      @(negedge clk);
      t++;
      if (out_valid && out_ready) hs++;
    end
    check("hs_count", 128'(hs), 128'(n));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    g_row = 0;
    g_col = 0;
    clear_stats();
    check("rst_out_valid", 128'(out_valid), 128'(1'b0));
    check("rst_in_ready", 128'(in_ready), 128'(1'b1));
    check("rst_intr", 128'(row_done_intr), 128'(1'b0));
  endtask

  task automatic run_three_rows(input string tag);
    send_pix(3 * IMG_W);
    wait_cycles(20);
    check({tag, "_latency"}, 128'(first_valid_cyc - acc24_cyc), 128'(2));
    check({tag, "_first_window"}, 128'(first_win), 128'(72'h22_21_20_12_11_10_02_01_00));
    check({tag, "_windows"}, 128'(win_cnt), 128'(NWIN));
    check({tag, "_intr"}, 128'(intr_cnt), 128'(1));
  endtask

  initial begin
    clear_stats();

    // Three rows, free-flowing output.
    or_mode = 0;
    or_fixed = 1'b1;
    do_reset();
    run_three_rows("s1");

    // Six rows: store rotation through all four line stores.
    do_reset();
    send_pix(6 * IMG_W);
    wait_cycles(20);
    check("s2_windows", 128'(win_cnt), 128'(4 * NWIN));
    check("s2_intr", 128'(intr_cnt), 128'(4));
    check("s2_row3_c0_i0", 128'(win_log[18][7:0]), 128'(8'h30));
    check("s2_row3_c0_i1", 128'(win_log[18][31:24]), 128'(8'h40));
    check("s2_row3_c0_i2", 128'(win_log[18][55:48]), 128'(8'h50));

    // Backpressure: output blocked, all four stores fill.
    do_reset();
    or_fixed = 1'b0;
    send_pix(4 * IMG_W);
    in_valid = 1'b1;
    in_data = pix(g_row, g_col);
    wait_cycles(20);
    check("s3_accepts_held", 128'(acc_cnt), 128'(32));
    check("s3_in_ready_low", 128'(in_ready), 128'(1'b0));
    check("s3_no_windows", 128'(win_cnt), 128'(0));
    or_fixed = 1'b1;
    send_pix(IMG_W);
    wait_cycles(30);
    check("s3_windows", 128'(win_cnt), 128'(3 * NWIN));
    check("s3_intr", 128'(intr_cnt), 128'(3));

    // Output stall: out_ready toggles every cycle.
    do_reset();
    or_mode = 1;
    send_pix(4 * IMG_W);
    wait_cycles(40);
    or_mode = 0;
    or_fixed = 1'b1;
    check("s4_windows", 128'(win_cnt), 128'(2 * NWIN));
    check("s4_intr", 128'(intr_cnt), 128'(2));

    // Last write of a row coincides with the last read handshake of a row.
    do_reset();
    or_fixed = 1'b0;
    send_pix(3 * IMG_W);
    or_fixed = 1'b1;
    wait_hs(NWIN - 1);
    or_fixed = 1'b0;
    @(posedge clk);
    #1;
    send_pix(IMG_W - 1);
    in_valid = 1'b1;
    in_data = pix(g_row, g_col);
    or_fixed = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    advance();
    @(negedge clk);
    check("s5_bubble_valid", 128'(out_valid), 128'(1'b0));
    check("s5_intr", 128'(row_done_intr), 128'(1'b1));
    check("s5_in_ready", 128'(in_ready), 128'(1'b1));
    @(negedge clk);
    check("s5_resume_valid", 128'(out_valid), 128'(1'b1));
    check("s5_resume_col0", 128'({out_window[55:48], out_window[31:24], out_window[7:0]}),
          128'(24'h30_20_10));
    @(posedge clk);
    #1;
    wait_cycles(20);
    check("s5_windows", 128'(win_cnt), 128'(2 * NWIN));

    // Reset in the middle of a row read, then replay the three-row stream.
    do_reset();
    send_pix(3 * IMG_W);
    wait_hs(3);
    @(posedge clk);
    #1;
    check("s6_pre_valid", 128'(out_valid), 128'(1'b1));
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("s6_out_valid", 128'(out_valid), 128'(1'b0));
    check("s6_in_ready", 128'(in_ready), 128'(1'b1));
    check("s6_intr", 128'(row_done_intr), 128'(1'b0));
    @(posedge clk);
    #1;
    g_row = 0;
    g_col = 0;
    clear_stats();
    run_three_rows("s6");

    // Randomized input gaps and output readiness over twenty rows.
    do_reset();
    gap_mode = 1'b1;
    or_mode = 2;
    send_pix(20 * IMG_W);
    gap_mode = 1'b0;
    or_mode = 0;
    or_fixed = 1'b1;
    wait_cycles(40);
    check("s7_windows", 128'(win_cnt), 128'(18 * NWIN));
    check("s7_intr", 128'(intr_cnt), 128'(18));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
